// File: rtl/digit_select_ctrl.sv
// -----------------------------------------------------------------------------
// digit_select_ctrl
//
// Sequencing controller around a 4-way single-nonzero digit decoder.
// On an accepted start the four operands are latched. Each CHECK cycle looks
// at the low DIGIT bits of every operand. The job stops on the first round in
// which exactly one operand has a nonzero low digit, and that operand's index
// is reported. Otherwise all operands shift right by DIGIT and the round is
// retried. The job gives up after MAX_ROUNDS rounds.
//
// Optional feature (macro DIGIT_SELECT_EARLY_FAIL_EN):
//   When defined, a round in which every operand register is entirely zero
//   fails at once instead of running on to the last round. Success results
//   are the same with or without the macro.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset; discards any in-flight job
//   start          request, sampled only in IDLE
//   a1..a4         operands, latched when start is accepted
//   busy           high from the cycle after start is accepted until ack
//   valid          result available, held until ack
//   found          1 = unique nonzero digit found, 0 = failure
//   idx            winning operand (a1=0 .. a4=3), 0 on failure
//   rounds         index of the deciding round (shift count applied)
//   ack            consumer accepts the result, sampled only while valid
// -----------------------------------------------------------------------------
module digit_select_ctrl #(
    parameter int WIDTH      = 32,
    parameter int DIGIT      = 5,
    parameter int MAX_ROUNDS = 7,
    parameter int RW         = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    input  logic [WIDTH-1:0] a4,
    output logic             busy,
    output logic             valid,
    output logic             found,
    output logic [1:0]       idx,
    output logic [RW-1:0]    rounds,
    input  logic             ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] r [4];
    logic [RW-1:0]    round;

    // Per-round decode of the operand registers.
    logic [3:0] nz;
    logic       unique_nz;
    logic [1:0] win_idx;
    logic       last_round;
    logic       early_fail;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        nz      = '0;
        win_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            nz[i] = |r[i][DIGIT-1:0];
        end
        // Exactly one bit set: nonzero and clearing the lowest set bit leaves 0.
        unique_nz = (nz != 4'd0) && ((nz & (nz - 4'd1)) == 4'd0);
        case (nz)
            4'b0001: win_idx = 2'd0;
            4'b0010: win_idx = 2'd1;
            4'b0100: win_idx = 2'd2;
            default: win_idx = 2'd3;
        endcase
    end

    assign last_round = (round == RW'(MAX_ROUNDS - 1));

`ifdef DIGIT_SELECT_EARLY_FAIL_EN
    // Nothing left to shift in: no later round can find a nonzero digit.
    assign early_fail = (r[0] == '0) && (r[1] == '0) && (r[2] == '0) && (r[3] == '0);
`else
    assign early_fail = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            round  <= '0;
            busy   <= 1'b0;
            valid  <= 1'b0;
            found  <= 1'b0;
            idx    <= 2'd0;
            rounds <= '0;
            // NOTE: the operand registers are cleared on reset too; a reset
            // abandons the job and leaves no stale operands behind.
            for (int i = 0; i < 4; i++) begin
                r[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        r[0]  <= a1;
                        r[1]  <= a2;
                        r[2]  <= a3;
                        r[3]  <= a4;
                        round <= '0;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end

                CHECK: begin
                    if (unique_nz) begin
                        found  <= 1'b1;
                        idx    <= win_idx;
                        rounds <= round;
                        valid  <= 1'b1;
                        state  <= DONE;
                    end else if (last_round || early_fail) begin
                        found  <= 1'b0;
                        idx    <= 2'd0;
                        rounds <= round;
                        valid  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            r[i] <= r[i] >> DIGIT;
                        end
                        round <= round + 1'b1;
                    end
                end

                DONE: begin
                    // A start arriving with ack is dropped; only ack matters here.
                    if (ack) begin
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_select_ctrl.sv
// -----------------------------------------------------------------------------
// tb_digit_select_ctrl
//
// Scoreboard bench for digit_select_ctrl. Each issued job pushes the result
// predicted by a digit-by-digit reference model (including the cycle in which
// valid must first rise). A monitor on the falling edge pops and compares when
// valid rises, and checks the result stays stable while valid is held.
// -----------------------------------------------------------------------------
module tb_digit_select_ctrl;

    localparam int WIDTH      = 32;
    localparam int DIGIT      = 5;
    localparam int MAX_ROUNDS = 7;
    localparam int RW         = 3;
    localparam int WAIT_LIMIT = 30;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a1, a2, a3, a4;
    logic             busy;
    logic             valid;
    logic             found;
    logic [1:0]       idx;
    logic [RW-1:0]    rounds;
    logic             ack;

    digit_select_ctrl #(
        .WIDTH      (WIDTH),
        .DIGIT      (DIGIT),
        .MAX_ROUNDS (MAX_ROUNDS),
        .RW         (RW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a1     (a1),
        .a2     (a2),
        .a3     (a3),
        .a4     (a4),
        .busy   (busy),
        .valid  (valid),
        .found  (found),
        .idx    (idx),
        .rounds (rounds),
        .ack    (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle number: advances on every rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          found;
        logic [1:0]    idx;
        logic [RW-1:0] rounds;
        int            vcyc;
    } exp_t;

    exp_t sb[$];

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: walk the digits of the original operands from the
    // least significant upward and pick the first digit position where
    // exactly one operand is nonzero.
    function automatic exp_t model(input logic [31:0] b1, input logic [31:0] b2,
                                   input logic [31:0] b3, input logic [31:0] b4,
                                   input int scyc);
        exp_t        e;
        logic [31:0] ops [4];
        ops[0] = b1; ops[1] = b2; ops[2] = b3; ops[3] = b4;
        for (int k = 0; k < MAX_ROUNDS; k++) begin
            int cnt  = 0;
            int who  = 0;
            bit left = 1'b0;
            for (int i = 0; i < 4; i++) begin
                logic [31:0] rest;
                rest = ops[i] >> (k * DIGIT);
                if ((rest % 32) != 0) begin
                    cnt++;
                    who = i;
                end
                if (rest != 0) left = 1'b1;
            end
            if (cnt == 1) begin
                e.found = 1'b1; e.idx = 2'(who); e.rounds = RW'(k); e.vcyc = scyc + k + 2;
                return e;
            end
`ifdef DIGIT_SELECT_EARLY_FAIL_EN
            if (!left) begin
                e.found = 1'b0; e.idx = 2'd0; e.rounds = RW'(k); e.vcyc = scyc + k + 2;
                return e;
            end
`endif
        end
        e.found = 1'b0; e.idx = 2'd0; e.rounds = RW'(MAX_ROUNDS - 1); e.vcyc = scyc + MAX_ROUNDS + 1;
        return e;
    endfunction

    // Monitor: compare on the rising edge of valid, then watch for stability.
    logic          prev_valid = 1'b0;
    logic          cap_found;
    logic [1:0]    cap_idx;
    logic [RW-1:0] cap_rounds;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("found",      32'(found),  32'(e.found));
                    check("idx",        32'(idx),    32'(e.idx));
                    check("rounds",     32'(rounds), 32'(e.rounds));
                    check("valid_cycle", 32'(cyc),   32'(e.vcyc));
                end
                cap_found  = found;
                cap_idx    = idx;
                cap_rounds = rounds;
            end else if (valid) begin
                check("result_stable", {26'd0, found, idx, rounds}, {26'd0, cap_found, cap_idx, cap_rounds});
            end
            if (valid) check("busy_with_valid", 32'(busy), 32'd1);
        end
        prev_valid <= valid;
    end

    // Wait (bounded) until the DUT is idle, then issue a job starting now.
    task automatic issue(input logic [31:0] b1, input logic [31:0] b2,
                         input logic [31:0] b3, input logic [31:0] b4);
        int n = 0;
        while ((busy || valid) && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (busy || valid) check("idle_timeout", 32'(busy | valid), 32'd0);
        a1 = b1; a2 = b2; a3 = b3; a4 = b4;
        start = 1'b1;
        sb.push_back(model(b1, b2, b3, b4, cyc));
        @(negedge clk);
        start = 1'b0;
        // Operands are don't-care once latched.
        a1 = $urandom; a2 = $urandom; a3 = $urandom; a4 = $urandom;
        check("busy_cycle1", 32'(busy), 32'd1);
    endtask

    // Wait (bounded) for valid, hold ack low for `hold` cycles (optionally
    // pulsing start), then acknowledge (optionally with start alongside).
    task automatic finish_job(input int hold, input bit pulse_start, input bit start_with_ack);
        int n = 0;
        while (!valid && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!valid) begin
            check("valid_timeout", 32'(valid), 32'd1);
            return;
        end
        for (int h = 0; h < hold; h++) begin
            start = pulse_start && (h == 0);
            @(negedge clk);
            start = 1'b0;
            check("valid_held", 32'(valid), 32'd1);
        end
        ack   = 1'b1;
        start = start_with_ack;
        @(negedge clk);
        ack   = 1'b0;
        start = 1'b0;
        check("valid_after_ack", 32'(valid), 32'd0);
        check("busy_after_ack",  32'(busy),  32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ack   = 1'b0;
        a1 = '0; a2 = '0; a3 = '0; a4 = '0;
        #1;
        check("reset_outputs", {25'd0, busy, valid, found, idx, rounds}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {30'd0, busy, valid}, 32'd0);

        // Directed jobs.
        issue(32'h0, 32'h0, 32'h7, 32'h0);        finish_job(0, 1'b0, 1'b0);
        issue(32'h20, 32'h0, 32'h0, 32'h0);       finish_job(0, 1'b0, 1'b0);
        issue(32'h1, 32'h1, 32'h0, 32'h40);       finish_job(0, 1'b0, 1'b0);
        issue(32'h0, 32'h0, 32'h0, 32'h0);        finish_job(0, 1'b0, 1'b0);
        // Ack withheld 3 cycles with start pulsed, then start alongside ack.
        issue(32'h0, 32'h400, 32'h0, 32'h0);      finish_job(3, 1'b1, 1'b1);
        @(negedge clk);
        check("start_with_ack_dropped", 32'(busy), 32'd0);
        // Shifting past the top of the operand leaves only zeros.
        issue(32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0); finish_job(1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of round 2 of a long job.
        issue(32'h8000, 32'h8000, 32'h0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {25'd0, busy, valid, found, idx, rounds}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("no_valid_after_reset", 32'(valid), 32'd0);
        issue(32'h0, 32'h0, 32'h7, 32'h0);        finish_job(0, 1'b0, 1'b0);

        // Randomized jobs with digits placed at random positions.
        for (int j = 0; j < 150; j++) begin
            logic [31:0] v [4];
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0:       v[i] = 32'h0;
                    1:       v[i] = 32'($urandom_range(1, 31)) << (DIGIT * $urandom_range(0, 6));
                    2:       v[i] = $urandom;
                    default: v[i] = 32'($urandom_range(0, 3)) << $urandom_range(0, 31);
                endcase
            end
            issue(v[0], v[1], v[2], v[3]);
            finish_job($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
